pipelined_register_file: RTL and testbench

Parametrised integer register file for the pipelined CPU. It replaces the single-cycle two-read-port file and adds:
- N read ports with write-to-read bypass.
- A pending-write scoreboard for hazard detection.
- A registered, sticky ecall halt detector.
- A single-register debug read port.
It sits between decode (reads, reserve) and writeback (write, release).

---
 rtl/pipelined_register_file.sv | 105 ++++++++++
 tb/tb_pipelined_register_file.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_register_file.sv
// Integer register file: N read ports with write forwarding, pending-write scoreboard, sticky ecall halt, debug read.
// Latency: reads and rs_busy are combinational; writes, busy bits and is_halted update on the next rising clk edge.
// Backpressure: none; rs_busy tells decode to stall, and the file always accepts writes and reserves.
module pipelined_register_file #(
    parameter int               XLEN           = 32,
    parameter int               NUM_REGS       = 32,
    parameter int               NUM_READ_PORTS = 2,
    parameter int               BYPASS_EN      = 1,
    parameter int               SP_IDX         = 2,
    parameter logic [XLEN-1:0]  SP_INIT        = 'h2ffc,
    parameter int               HALT_REG       = 17,
    parameter logic [XLEN-1:0]  HALT_CODE      = 'd10,
    localparam int              AW             = $clog2(NUM_REGS)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_READ_PORTS*AW-1:0]   rs_addr,
    output logic [NUM_READ_PORTS*XLEN-1:0] rs_dout,
    output logic [NUM_READ_PORTS-1:0]      rs_busy,
    input  logic                           wr_en,
    input  logic [AW-1:0]                  wr_addr,
    input  logic [XLEN-1:0]                wr_data,
    input  logic                           rsv_en,
    input  logic [AW-1:0]                  rsv_addr,
    input  logic                           is_ecall,
    output logic                           is_halted,
    input  logic [AW-1:0]                  dbg_addr,
    output logic [XLEN-1:0]                dbg_dout
);

    localparam logic [AW-1:0] HALT_A = AW'(HALT_REG);
    localparam bit            BYP    = (BYPASS_EN != 0);

    logic [XLEN-1:0]     rf [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_nxt;
    logic                wr_live;
    logic                rsv_live;
    logic                halt_fwd;
    logic [XLEN-1:0]     halt_val;
    logic                halt_req;

    // x0 is hardwired: writes and reservations aimed at it never touch state
    assign wr_live  = wr_en  && (wr_addr  != '0);
    assign rsv_live = rsv_en && (rsv_addr != '0);

    for (genvar k = 0; k < NUM_READ_PORTS; k++) begin : g_rd
        logic [AW-1:0] a;
        logic          fwd;
        assign a   = rs_addr[k*AW +: AW];
        // a same-cycle write to this register both supplies the data and releases the hazard
        assign fwd = BYP && wr_en && (wr_addr == a);
        assign rs_dout[k*XLEN +: XLEN] = (a == '0) ? '0 : (fwd ? wr_data : rf[a]);
        assign rs_busy[k]              = (a != '0) && busy[a] && !fwd;
    end

    // halt compares the value decode would see, so it follows the same forwarding rule as the read ports
    assign halt_fwd = BYP && wr_en && (wr_addr == HALT_A);
    assign halt_val = (HALT_A == '0) ? '0 : (halt_fwd ? wr_data : rf[HALT_A]);
    assign halt_req = is_ecall && (halt_val == HALT_CODE);

    // debug port shows architectural state only, never forwarded data
    assign dbg_dout = (dbg_addr == '0) ? '0 : rf[dbg_addr];

    // register array: reset clears everything except the stack pointer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rf[i] <= (i == SP_IDX) ? SP_INIT : '0;
            end
        end else if (wr_live) begin
            rf[wr_addr] <= wr_data;
        end
    end

    // next busy vector: writeback releases first so a same-cycle reservation of that register wins
    always_comb begin
        busy_nxt = busy;
        if (wr_live) begin
            busy_nxt[wr_addr] = 1'b0;
        end
        if (rsv_live) begin
            busy_nxt[rsv_addr] = 1'b1;
        end
    end

    // pending-write scoreboard, one bit per register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    // sticky halt flag, cleared only by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            is_halted <= 1'b0;
        end else if (halt_req) begin
            is_halted <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pipelined_register_file.sv
module tb_pipelined_register_file;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // default instance: XLEN=32, 2 ports, bypass on
    logic [9:0]  rs_addr;
    logic [63:0] rs_dout;
    logic [1:0]  rs_busy;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic        is_ecall;
    logic        is_halted;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_dout;

    // wide instance: XLEN=64, 4 ports, bypass off
    logic [19:0]  w_rs_addr;
    logic [255:0] w_rs_dout;
    logic [3:0]   w_rs_busy;
    logic         w_wr_en;
    logic [4:0]   w_wr_addr;
    logic [63:0]  w_wr_data;
    logic         w_rsv_en;
    logic [4:0]   w_rsv_addr;
    logic         w_is_ecall;
    logic         w_is_halted;
    logic [4:0]   w_dbg_addr;
    logic [63:0]  w_dbg_dout;

    pipelined_register_file dut (
        .clk(clk), .reset(rst_n),
        .rs_addr(rs_addr), .rs_dout(rs_dout), .rs_busy(rs_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .is_ecall(is_ecall), .is_halted(is_halted),
        .dbg_addr(dbg_addr), .dbg_dout(dbg_dout)
    );

    pipelined_register_file #(.XLEN(64), .NUM_READ_PORTS(4), .BYPASS_EN(0)) dut_w (
        .clk(clk), .reset(rst_n),
        .rs_addr(w_rs_addr), .rs_dout(w_rs_dout), .rs_busy(w_rs_busy),
        .wr_en(w_wr_en), .wr_addr(w_wr_addr), .wr_data(w_wr_data),
        .rsv_en(w_rsv_en), .rsv_addr(w_rsv_addr),
        .is_ecall(w_is_ecall), .is_halted(w_is_halted),
        .dbg_addr(w_dbg_addr), .dbg_dout(w_dbg_dout)
    );

    int total = 0;
    int bad = 0;
    logic [63:0] sb_q[$];
    logic [63:0] e;

    task automatic idle();
        wr_en = 0; wr_addr = 0; wr_data = 0; rsv_en = 0; rsv_addr = 0; is_ecall = 0;
        w_wr_en = 0; w_wr_addr = 0; w_wr_data = 0; w_rsv_en = 0; w_rsv_addr = 0; w_is_ecall = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle();
        rs_addr = {5'd5, 5'd2}; dbg_addr = 5'd2;
        w_rs_addr = '0; w_dbg_addr = '0;
        @(negedge clk); @(negedge clk);
        #2;
        sb_q.push_back(64'h2ffc); sb_q.push_back(64'h0); sb_q.push_back(64'h0);
        sb_q.push_back(64'h0); sb_q.push_back(64'h2ffc);
        total++; e = sb_q.pop_front();
        if ({32'b0, rs_dout[31:0]} !== e) begin bad++; $display("FAIL reset_x2 got=%h want=%h", rs_dout[31:0], e[31:0]); end
        total++; e = sb_q.pop_front();
        if ({32'b0, rs_dout[63:32]} !== e) begin bad++; $display("FAIL reset_x5 got=%h want=%h", rs_dout[63:32], e[31:0]); end
        total++; e = sb_q.pop_front();
        if ({62'b0, rs_busy} !== e) begin bad++; $display("FAIL reset_busy got=%b want=%b", rs_busy, e[1:0]); end
        total++; e = sb_q.pop_front();
        if ({63'b0, is_halted} !== e) begin bad++; $display("FAIL reset_halt got=%b want=%b", is_halted, e[0]); end
        total++; e = sb_q.pop_front();
        if ({32'b0, dbg_dout} !== e) begin bad++; $display("FAIL reset_dbg_x2 got=%h want=%h", dbg_dout, e[31:0]); end
        rst_n = 1;
    endtask

    task automatic test_bypass();
        @(negedge clk);
        rs_addr = {5'd7, 5'd7}; dbg_addr = 5'd7;
        wr_en = 1; wr_addr = 5'd7; wr_data = 32'hdeadbeef;
        w_rs_addr = {15'd0, 5'd7}; w_wr_en = 1; w_wr_addr = 5'd7; w_wr_data = 64'hdeadbeef;
        sb_q.push_back(64'hdeadbeef); sb_q.push_back(64'hdeadbeef);
        sb_q.push_back(64'h0); sb_q.push_back(64'h0);
        #2;
        total++; e = sb_q.pop_front();
        if ({32'b0, rs_dout[31:0]} !== e) begin bad++; $display("FAIL bypass_p0 got=%h want=%h", rs_dout[31:0], e[31:0]); end
        total++; e = sb_q.pop_front();
        if ({32'b0, rs_dout[63:32]} !== e) begin bad++; $display("FAIL bypass_p1 got=%h want=%h", rs_dout[63:32], e[31:0]); end
        total++; e = sb_q.pop_front();
        if ({32'b0, dbg_dout} !== e) begin bad++; $display("FAIL bypass_dbg_nofwd got=%h want=%h", dbg_dout, e[31:0]); end
        total++; e = sb_q.pop_front();
        if (w_rs_dout[63:0] !== e) begin bad++; $display("FAIL nobypass_old got=%h want=%h", w_rs_dout[63:0], e); end
        @(negedge clk);
        idle();
        sb_q.push_back(64'hdeadbeef); sb_q.push_back(64'hdeadbeef); sb_q.push_back(64'hdeadbeef);
        #2;
        total++; e = sb_q.pop_front();
        if ({32'b0, rs_dout[31:0]} !== e) begin bad++; $display("FAIL after_write_p0 got=%h want=%h", rs_dout[31:0], e[31:0]); end
        total++; e = sb_q.pop_front();
        if ({32'b0, dbg_dout} !== e) begin bad++; $display("FAIL after_write_dbg got=%h want=%h", dbg_dout, e[31:0]); end
        total++; e = sb_q.pop_front();
        if (w_rs_dout[63:0] !== e) begin bad++; $display("FAIL nobypass_next got=%h want=%h", w_rs_dout[63:0], e); end
    endtask

    task automatic test_x0();
        @(negedge clk);
        rs_addr = {5'd0, 5'd0}; dbg_addr = 5'd0;
        wr_en = 1; wr_addr = 5'd0; wr_data = 32'hffffffff; rsv_en = 1; rsv_addr = 5'd0;
        sb_q.push_back(64'h0); sb_q.push_back(64'h0);
        #2;
        total++; e = sb_q.pop_front();
        if ({32'b0, rs_dout[63:32]} !== e || {32'b0, rs_dout[31:0]} !== e) begin bad++; $display("FAIL x0_read_fwd got=%h want=%h", rs_dout, e); end
        total++; e = sb_q.pop_front();
        if ({62'b0, rs_busy} !== e) begin bad++; $display("FAIL x0_busy_fwd got=%b want=%b", rs_busy, e[1:0]); end
        @(negedge clk);
        idle();
        sb_q.push_back(64'h0); sb_q.push_back(64'h0); sb_q.push_back(64'h0);
        #2;
        total++; e = sb_q.pop_front();
        if ({32'b0, rs_dout[31:0]} !== e) begin bad++; $display("FAIL x0_read got=%h want=%h", rs_dout[31:0], e[31:0]); end
        total++; e = sb_q.pop_front();
        if ({62'b0, rs_busy} !== e) begin bad++; $display("FAIL x0_busy got=%b want=%b", rs_busy, e[1:0]); end
        total++; e = sb_q.pop_front();
        if ({32'b0, dbg_dout} !== e) begin bad++; $display("FAIL x0_dbg got=%h want=%h", dbg_dout, e[31:0]); end
    endtask

    task automatic test_scoreboard();
        // each row: wr_en, rsv_en, data, expected main busy, main data, wide busy, wide data
        logic        t_wr [5]  = '{0, 0, 1, 0, 1};
        logic        t_rsv[5]  = '{1, 1, 1, 0, 0};
        logic [31:0] t_dat[5]  = '{0, 0, 32'h99, 0, 32'haa};
        logic        x_mb [5]  = '{0, 1, 0, 1, 0};
        logic [31:0] x_md [5]  = '{0, 0, 32'h99, 32'h99, 32'haa};
        logic        x_wb [5]  = '{0, 1, 1, 1, 1};
        logic [31:0] x_wd [5]  = '{0, 0, 0, 32'h99, 32'h99};
        rs_addr = {5'd0, 5'd9}; w_rs_addr = {15'd0, 5'd9};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            idle();
            wr_en = t_wr[i]; wr_addr = 5'd9; wr_data = t_dat[i]; rsv_en = t_rsv[i]; rsv_addr = 5'd9;
            w_wr_en = t_wr[i]; w_wr_addr = 5'd9; w_wr_data = {32'b0, t_dat[i]}; w_rsv_en = t_rsv[i]; w_rsv_addr = 5'd9;
            sb_q.push_back({63'b0, x_mb[i]}); sb_q.push_back({32'b0, x_md[i]});
            sb_q.push_back({63'b0, x_wb[i]}); sb_q.push_back({32'b0, x_wd[i]});
            #2;
            total++; e = sb_q.pop_front();
            if ({63'b0, rs_busy[0]} !== e) begin bad++; $display("FAIL sb_busy step%0d got=%b want=%b", i, rs_busy[0], e[0]); end
            total++; e = sb_q.pop_front();
            if ({32'b0, rs_dout[31:0]} !== e) begin bad++; $display("FAIL sb_data step%0d got=%h want=%h", i, rs_dout[31:0], e[31:0]); end
            total++; e = sb_q.pop_front();
            if ({63'b0, w_rs_busy[0]} !== e) begin bad++; $display("FAIL sb_nobyp_busy step%0d got=%b want=%b", i, w_rs_busy[0], e[0]); end
            total++; e = sb_q.pop_front();
            if (w_rs_dout[63:0] !== e) begin bad++; $display("FAIL sb_nobyp_data step%0d got=%h want=%h", i, w_rs_dout[63:0], e); end
        end
        @(negedge clk);
        idle();
        sb_q.push_back(64'h0); sb_q.push_back(64'h0); sb_q.push_back(64'haa);
        #2;
        total++; e = sb_q.pop_front();
        if ({63'b0, rs_busy[0]} !== e) begin bad++; $display("FAIL sb_release got=%b want=%b", rs_busy[0], e[0]); end
        total++; e = sb_q.pop_front();
        if ({63'b0, w_rs_busy[0]} !== e) begin bad++; $display("FAIL sb_nobyp_release got=%b want=%b", w_rs_busy[0], e[0]); end
        total++; e = sb_q.pop_front();
        if ({32'b0, rs_dout[31:0]} !== e) begin bad++; $display("FAIL sb_final_data got=%h want=%h", rs_dout[31:0], e[31:0]); end
    endtask

    task automatic test_halt();
        @(negedge clk);
        rs_addr = {5'd4, 5'd17};
        wr_en = 1; wr_addr = 5'd17; wr_data = 32'd10; is_ecall = 1;
        sb_q.push_back(64'h0); sb_q.push_back(64'd10);
        #2;
        total++; e = sb_q.pop_front();
        if ({63'b0, is_halted} !== e) begin bad++; $display("FAIL halt_early got=%b want=%b", is_halted, e[0]); end
        total++; e = sb_q.pop_front();
        if ({32'b0, rs_dout[31:0]} !== e) begin bad++; $display("FAIL halt_x17_fwd got=%h want=%h", rs_dout[31:0], e[31:0]); end
        @(negedge clk);
        idle();
        sb_q.push_back(64'h1);
        #2;
        total++; e = sb_q.pop_front();
        if ({63'b0, is_halted} !== e) begin bad++; $display("FAIL halt_set got=%b want=%b", is_halted, e[0]); end
        @(negedge clk);
        dbg_addr = 5'd3;
        wr_en = 1; wr_addr = 5'd3; wr_data = 32'h33; rsv_en = 1; rsv_addr = 5'd4;
        @(negedge clk);
        idle();
        @(negedge clk); @(negedge clk);
        sb_q.push_back(64'h1); sb_q.push_back(64'h33); sb_q.push_back(64'h1);
        #2;
        total++; e = sb_q.pop_front();
        if ({63'b0, is_halted} !== e) begin bad++; $display("FAIL halt_sticky got=%b want=%b", is_halted, e[0]); end
        total++; e = sb_q.pop_front();
        if ({32'b0, dbg_dout} !== e) begin bad++; $display("FAIL halt_write_ok got=%h want=%h", dbg_dout, e[31:0]); end
        total++; e = sb_q.pop_front();
        if ({63'b0, rs_busy[1]} !== e) begin bad++; $display("FAIL halt_rsv_ok got=%b want=%b", rs_busy[1], e[0]); end
    endtask

    task automatic test_reset_midrun();
        @(negedge clk);
        rs_addr = {5'd6, 5'd5};
        wr_en = 1; wr_addr = 5'd5; wr_data = 32'h1234; rsv_en = 1; rsv_addr = 5'd6;
        @(negedge clk);
        idle();
        sb_q.push_back(64'h1234); sb_q.push_back(64'h1);
        #2;
        total++; e = sb_q.pop_front();
        if ({32'b0, rs_dout[31:0]} !== e) begin bad++; $display("FAIL pre_reset_x5 got=%h want=%h", rs_dout[31:0], e[31:0]); end
        total++; e = sb_q.pop_front();
        if ({63'b0, rs_busy[1]} !== e) begin bad++; $display("FAIL pre_reset_busy got=%b want=%b", rs_busy[1], e[0]); end
        rst_n = 0;
        sb_q.push_back(64'h0); sb_q.push_back(64'h0); sb_q.push_back(64'h0);
        #1;
        total++; e = sb_q.pop_front();
        if ({32'b0, rs_dout[31:0]} !== e) begin bad++; $display("FAIL async_reset_x5 got=%h want=%h", rs_dout[31:0], e[31:0]); end
        total++; e = sb_q.pop_front();
        if ({62'b0, rs_busy} !== e) begin bad++; $display("FAIL async_reset_busy got=%b want=%b", rs_busy, e[1:0]); end
        total++; e = sb_q.pop_front();
        if ({63'b0, is_halted} !== e) begin bad++; $display("FAIL async_reset_halt got=%b want=%b", is_halted, e[0]); end
        rs_addr = {5'd2, 5'd5};
        sb_q.push_back(64'h2ffc);
        #1;
        total++; e = sb_q.pop_front();
        if ({32'b0, rs_dout[63:32]} !== e) begin bad++; $display("FAIL async_reset_sp got=%h want=%h", rs_dout[63:32], e[31:0]); end
        // state must hold across an edge while reset stays low
        rs_addr = {5'd6, 5'd5}; dbg_addr = 5'd5;
        wr_en = 1; wr_addr = 5'd5; wr_data = 32'h55; rsv_en = 1; rsv_addr = 5'd6;
        @(negedge clk);
        idle();
        sb_q.push_back(64'h0); sb_q.push_back(64'h0);
        #2;
        total++; e = sb_q.pop_front();
        if ({32'b0, dbg_dout} !== e) begin bad++; $display("FAIL reset_hold_x5 got=%h want=%h", dbg_dout, e[31:0]); end
        total++; e = sb_q.pop_front();
        if ({62'b0, rs_busy} !== e) begin bad++; $display("FAIL reset_hold_busy got=%b want=%b", rs_busy, e[1:0]); end
        rst_n = 1;
    endtask

    task automatic test_halt_miss();
        // rows: wr_en, data, ecall; then expected is_halted one edge later
        logic        t_wr [6] = '{1, 1, 0, 1, 0, 0};
        logic [31:0] t_dat[6] = '{10, 9, 0, 10, 0, 0};
        logic        t_ec [6] = '{0, 1, 1, 0, 1, 0};
        logic        x_h  [6] = '{0, 0, 0, 0, 1, 1};
        rs_addr = {5'd0, 5'd17};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            idle();
            wr_en = t_wr[i]; wr_addr = 5'd17; wr_data = t_dat[i]; is_ecall = t_ec[i];
            @(negedge clk);
            idle();
            sb_q.push_back({63'b0, x_h[i]});
            #2;
            total++; e = sb_q.pop_front();
            if ({63'b0, is_halted} !== e) begin bad++; $display("FAIL halt_seq step%0d got=%b want=%b", i, is_halted, e[0]); end
        end
    endtask

    task automatic test_wide();
        logic [63:0] init_v[4] = '{64'h0, 64'h2ffc, 64'h0, 64'h0};
        @(negedge clk);
        idle();
        w_rs_addr = {5'd4, 5'd3, 5'd2, 5'd1}; w_dbg_addr = 5'd4;
        for (int k = 0; k < 4; k++) sb_q.push_back(init_v[k]);
        #2;
        for (int k = 0; k < 4; k++) begin
            total++; e = sb_q.pop_front();
            if (w_rs_dout[k*64 +: 64] !== e) begin bad++; $display("FAIL wide_init port%0d got=%h want=%h", k, w_rs_dout[k*64 +: 64], e); end
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            w_wr_en = 1; w_wr_addr = 5'(k + 1); w_wr_data = 64'(k + 1);
        end
        @(negedge clk);
        idle();
        for (int k = 0; k < 4; k++) sb_q.push_back(64'(k + 1));
        sb_q.push_back(64'h4);
        #2;
        for (int k = 0; k < 4; k++) begin
            total++; e = sb_q.pop_front();
            if (w_rs_dout[k*64 +: 64] !== e) begin bad++; $display("FAIL wide_read port%0d got=%h want=%h", k, w_rs_dout[k*64 +: 64], e); end
        end
        total++; e = sb_q.pop_front();
        if (w_dbg_dout !== e) begin bad++; $display("FAIL wide_dbg got=%h want=%h", w_dbg_dout, e); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] prev;
        logic [31:0] d;
        prev = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            d = $urandom;
            wr_en = 1; wr_addr = 5'(10 + i); wr_data = d;
            rs_addr = {(i == 0) ? 5'd0 : 5'(9 + i), 5'(10 + i)};
            sb_q.push_back({32'b0, d}); sb_q.push_back({32'b0, prev});
            #2;
            total++; e = sb_q.pop_front();
            if ({32'b0, rs_dout[31:0]} !== e) begin bad++; $display("FAIL b2b_fwd step%0d got=%h want=%h", i, rs_dout[31:0], e[31:0]); end
            total++; e = sb_q.pop_front();
            if ({32'b0, rs_dout[63:32]} !== e) begin bad++; $display("FAIL b2b_prev step%0d got=%h want=%h", i, rs_dout[63:32], e[31:0]); end
            prev = d;
        end
        @(negedge clk);
        idle();
        rs_addr = {5'd0, 5'd15};
        sb_q.push_back({32'b0, prev});
        #2;
        total++; e = sb_q.pop_front();
        if ({32'b0, rs_dout[31:0]} !== e) begin bad++; $display("FAIL b2b_last got=%h want=%h", rs_dout[31:0], e[31:0]); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rs_addr = '0; dbg_addr = '0; w_rs_addr = '0; w_dbg_addr = '0;
        test_reset();
        test_bypass();
        test_x0();
        test_scoreboard();
        test_halt();
        test_reset_midrun();
        test_halt_miss();
        test_wide();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
